// File: rtl/freqdiv_pkg.sv
// Shared definitions for the multi-channel frequency divider.
//   FREQDIV_WIDTH_DEFAULT : default counter / divide-value width
//   FREQDIV_NCH_DEFAULT   : default number of channels
//   freqdiv_chan_w()      : width of the channel-select field (clog2, at least 1)
//   freqdiv_div_t         : divide value at the default width
package freqdiv_pkg;

  localparam int FREQDIV_WIDTH_DEFAULT = 20;
  localparam int FREQDIV_NCH_DEFAULT   = 4;

  // A single channel still needs a one-bit select so the port never collapses.
  function automatic int freqdiv_chan_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  typedef logic [FREQDIV_WIDTH_DEFAULT-1:0] freqdiv_div_t;

endpackage

// File: rtl/freqdiv_chan.sv
// One divider channel: counter, active and shadow divide values, Tick strobe
// and 50%-duty square wave.
// Ports:
//   Clk, Rst      rising-edge clock, synchronous active-high reset
//   En            run enable; low clears the counter and holds SqOut
//   WrSel         this channel is the target of a divide-value write
//   WrDiv         new divide value D (period D+1) for the shadow register
//   SyncIn        (only with FREQDIV_SYNC_EN) restart the channel from zero
//   Tick          one-cycle strobe per period, registered
//   SqOut         toggles with every Tick, registered
// Optional macro: FREQDIV_SYNC_EN adds SyncIn.
module freqdiv_chan
  import freqdiv_pkg::*;
#(
  parameter int               WIDTH       = FREQDIV_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             WrSel,
  input  logic [WIDTH-1:0] WrDiv,
`ifdef FREQDIV_SYNC_EN
  input  logic             SyncIn,
`endif
  output logic             Tick,
  output logic             SqOut
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_shd_q, div_shd_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             wrap;

  // cnt never exceeds div_act: div_act only changes when cnt is cleared, so
  // the increment cannot wrap even at the all-ones divide value.
  assign wrap = (cnt_q == div_act_q);

  always_comb begin
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    div_shd_d = div_shd_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;

    if (!En) begin
      // Idle channel picks up any pending value so re-enable starts clean.
      cnt_d     = '0;
      div_act_d = div_shd_q;
    end else if (wrap) begin
      // The wrap consumes the shadow value as it was before this edge.
      cnt_d     = '0;
      div_act_d = div_shd_q;
      tick_d    = 1'b1;
      sq_d      = ~sq_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

`ifdef FREQDIV_SYNC_EN
    if (SyncIn) begin
      cnt_d     = '0;
      div_act_d = div_shd_q;
      tick_d    = 1'b0;
      sq_d      = 1'b0;
    end
`endif

    // The shadow write is independent of wrap, enable and sync.
    if (WrSel) begin
      div_shd_d = WrDiv;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q     <= '0;
      div_act_q <= DEFAULT_DIV;
      div_shd_q <= DEFAULT_DIV;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      div_shd_q <= div_shd_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
    end
  end

  assign Tick  = tick_q;
  assign SqOut = sq_q;

endmodule

// File: rtl/freqdiv_multi.sv
// Multi-channel programmable frequency divider / clock-enable generator.
// Each channel emits a one-cycle Tick every D+1 enabled cycles and a square
// wave of period 2*(D+1).
// Ports:
//   Clk, Rst   rising-edge clock, synchronous active-high reset
//   ChanEn     per-channel run enable
//   WrEn       single-cycle divide-value write strobe
//   WrChan     write target channel; values >= NCH are ignored
//   WrDiv      new divide value D, applied at the channel's next wrap
//   Tick       per-channel period strobe
//   SqOut      per-channel 50%-duty square wave
//   SyncIn     (only with FREQDIV_SYNC_EN) realigns every channel
// Optional macro: FREQDIV_SYNC_EN adds SyncIn.
module freqdiv_multi
  import freqdiv_pkg::*;
#(
  parameter int               NCH         = FREQDIV_NCH_DEFAULT,
  parameter int               WIDTH       = FREQDIV_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = '1
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic [NCH-1:0]                   ChanEn,
  input  logic                             WrEn,
  input  logic [freqdiv_chan_w(NCH)-1:0]   WrChan,
  input  logic [WIDTH-1:0]                 WrDiv,
`ifdef FREQDIV_SYNC_EN
  input  logic                             SyncIn,
`endif
  output logic [NCH-1:0]                   Tick,
  output logic [NCH-1:0]                   SqOut
);

  logic [NCH-1:0] wr_sel;

  // Out-of-range channel numbers match no channel, so they drop silently.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_sel[i] = WrEn && (int'(WrChan) == i);
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    freqdiv_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .Clk    (Clk),
      .Rst    (Rst),
      .En     (ChanEn[i]),
      .WrSel  (wr_sel[i]),
      .WrDiv  (WrDiv),
`ifdef FREQDIV_SYNC_EN
      .SyncIn (SyncIn),
`endif
      .Tick   (Tick[i]),
      .SqOut  (SqOut[i])
    );
  end

endmodule

// File: tb/tb_freqdiv_multi.sv
module tb_freqdiv_multi;
  import freqdiv_pkg::*;

  localparam int NCH     = 5;
  localparam int WIDTH   = 6;
  localparam int CW      = freqdiv_chan_w(NCH);
  localparam int DEF_PER = 1 << WIDTH;   // DEFAULT_DIV is all ones
`ifdef FREQDIV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Rst;
  logic [NCH-1:0]   ChanEn;
  logic             WrEn;
  logic [CW-1:0]    WrChan;
  logic [WIDTH-1:0] WrDiv;
  logic [NCH-1:0]   Tick;
  logic [NCH-1:0]   SqOut;
`ifdef FREQDIV_SYNC_EN
  logic             SyncIn;
`endif

  freqdiv_multi #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .ChanEn (ChanEn),
    .WrEn   (WrEn),
    .WrChan (WrChan),
    .WrDiv  (WrDiv),
`ifdef FREQDIV_SYNC_EN
    .SyncIn (SyncIn),
`endif
    .Tick   (Tick),
    .SqOut  (SqOut)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model: each channel tracks how many enabled edges have elapsed
  // in the current period, the length of that period, and the period length
  // queued by the most recent write.
  int             elapsed [NCH];
  int             period  [NCH];
  int             pending [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_sq;

  task automatic model_step(input logic rst, input logic [NCH-1:0] en, input logic wr,
                            input int ch, input int dv, input logic sy);
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        elapsed[i] = 0;
        period[i]  = DEF_PER;
        pending[i] = DEF_PER;
      end
      m_tick = '0;
      m_sq   = '0;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      m_tick[i] = 1'b0;
      if (SYNC_ON && sy) begin
        elapsed[i] = 0;
        period[i]  = pending[i];
        m_sq[i]    = 1'b0;
      end else if (!en[i]) begin
        elapsed[i] = 0;
        period[i]  = pending[i];
      end else begin
        elapsed[i]++;
        if (elapsed[i] == period[i]) begin
          m_tick[i]  = 1'b1;
          m_sq[i]    = ~m_sq[i];
          elapsed[i] = 0;
          period[i]  = pending[i];
        end
      end
      if (wr && ch == i) pending[i] = dv + 1;
    end
  endtask

  task automatic cycle(input logic rst, input logic [NCH-1:0] en, input logic wr,
                       input int ch, input int dv, input logic sy);
    Rst    = rst;
    ChanEn = en;
    WrEn   = wr;
    WrChan = CW'(ch);
    WrDiv  = WIDTH'(dv);
`ifdef FREQDIV_SYNC_EN
    SyncIn = sy;
`endif
    @(posedge Clk);
    model_step(rst, en, wr, ch, dv, sy);
    #1;
    chk("tick", 64'(Tick), 64'(m_tick));
    chk("sqout", 64'(SqOut), 64'(m_sq));
  endtask

  task automatic idle(input logic [NCH-1:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, en, 1'b0, 0, 0, 1'b0);
  endtask

  logic [NCH-1:0] en_r;
  int             guard;

  initial begin
    m_tick = '0;
    m_sq   = '0;
    // Reset and idle state
    cycle(1'b1, '0, 1'b0, 0, 0, 1'b0);
    cycle(1'b1, '0, 1'b0, 0, 0, 1'b0);
    idle('0, 3);

    // D=3 on ch0
    cycle(1'b0, '0, 1'b1, 0, 3, 1'b0);
    idle(5'b00001, 20);

    // D=0 on ch1: constant Tick
    cycle(1'b0, 5'b00001, 1'b1, 1, 0, 1'b0);
    idle(5'b00011, 10);

    // ch2 at D=9, rewrite to D=2 mid-period
    cycle(1'b0, 5'b00011, 1'b1, 2, 9, 1'b0);
    idle(5'b00111, 5);
    cycle(1'b0, 5'b00111, 1'b1, 2, 2, 1'b0);
    idle(5'b00111, 20);

    // Write landing exactly on ch2's wrap edge
    guard = 0;
    while (elapsed[2] + 1 != period[2] && guard < 100) begin
      idle(5'b00111, 1);
      guard++;
    end
    chk("wrap_wait", 64'(guard < 100), 64'd1);
    cycle(1'b0, 5'b00111, 1'b1, 2, 5, 1'b0);
    idle(5'b00111, 20);

    // Disable ch0 at cnt=2, re-enable after 5 cycles
    guard = 0;
    while (elapsed[0] != 2 && guard < 100) begin
      idle(5'b00111, 1);
      guard++;
    end
    chk("cnt2_wait", 64'(guard < 100), 64'd1);
    idle(5'b00110, 5);
    idle(5'b00111, 12);

    // Reset with a simultaneous write, then an out-of-range channel write
    cycle(1'b1, 5'b00111, 1'b1, 0, 7, 1'b0);
    idle(5'b11111, 10);
    cycle(1'b0, 5'b11111, 1'b1, 7, 1, 1'b0);
    idle(5'b11111, 2 * DEF_PER + 4);

    // Largest divide value on ch3, plus realignment with ch0=3 / ch1=5
    cycle(1'b0, 5'b11111, 1'b1, 3, DEF_PER - 1, 1'b0);
    cycle(1'b0, 5'b11111, 1'b1, 0, 3, 1'b0);
    cycle(1'b0, 5'b11111, 1'b1, 1, 5, 1'b0);
    idle(5'b11111, 2 * DEF_PER + 5);
    cycle(1'b0, 5'b11111, 1'b0, 0, 0, 1'b1);
    idle(5'b11111, 12);

    // Randomized operation
    en_r = 5'b11111;
    for (int n = 0; n < 3000; n++) begin
      logic          r_rst, r_wr, r_sy;
      int            r_ch, r_dv;
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 15) == 0) en_r[i] = ~en_r[i];
      r_rst = ($urandom_range(0, 299) == 0);
      r_wr  = ($urandom_range(0, 3) == 0);
      r_sy  = ($urandom_range(0, 59) == 0);
      r_ch  = $urandom_range(0, 7);
      r_dv  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEF_PER - 1);
      cycle(r_rst, en_r, r_wr, r_ch, r_dv, r_sy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
